// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - RV32M funct3 encodings
//   - decoder group codes for is_muldiv (also consumed by the decoder)
//   - FSM state type for muldiv_unit
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] MULDIV_GRP_MUL = 2'b01;
   localparam logic [1:0] MULDIV_GRP_DIV = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StFix
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: one combinational step of unsigned radix-2 restoring division.
// Ports:
//   rem_in   partial remainder so far (always < divisor)
//   quo_in   shift register: remaining dividend bits (MSB next), quotient bits fill from LSB
//   divisor  unsigned divisor (non-zero)
//   rem_out  updated partial remainder
//   quo_out  quo_in shifted left by one with the new quotient bit in the LSB
module div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_in, quo_in[XLEN-1]};
   assign diff    = shifted - {1'b0, divisor};

   // diff[XLEN] set means the trial subtraction borrowed: restore.
   assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   request handshake; ready_o only in idle
//   is_muldiv_i         decoder group (01 mul, 10 div); gates acceptance only
//   funct3_i            RV32M funct3, selects the operation
//   op_a_i, op_b_i      rs1 / rs2 values
//   rd_i                destination tag
//   flush_i             aborts any operation in flight, blocks accept in idle
//   valid_o             one-cycle result strobe
//   result_o, rd_o      registered result and tag, held between strobes
//   busy_o              inverse of ready_o
// Multiply: 2-cycle latency. Divide: restoring, one bit per cycle, then a sign-fix
// cycle; divide-by-zero and signed overflow skip straight to the fix cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [1:0]            is_muldiv_i,
   input  logic [2:0]            funct3_i,
   input  logic [XLEN-1:0]       op_a_i,
   input  logic [XLEN-1:0]       op_b_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  flush_i,
   output logic                  valid_o,
   output logic [XLEN-1:0]       result_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic                  busy_o
);

   localparam int unsigned     CntW    = $clog2(XLEN) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
   localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]       a_q, a_d;
   logic [XLEN-1:0]       b_q, b_d;
   logic [XLEN-1:0]       rem_q, rem_d;
   logic [XLEN-1:0]       quo_q, quo_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  valid_q, valid_d;
   logic [XLEN-1:0]       result_q, result_d;
   logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;

   logic                  accept;
   logic                  div_signed, a_neg, b_neg;
   logic [XLEN-1:0]       abs_a, abs_b;
   logic                  a_sx, b_sx;
   logic [2*XLEN-1:0]     prod;
   logic [XLEN-1:0]       step_rem, step_quo;

   assign accept = valid_i && (state_q == StIdle) && !flush_i &&
                   (is_muldiv_i == MULDIV_GRP_MUL || is_muldiv_i == MULDIV_GRP_DIV);

   // DIV and REM (funct3[0] == 0) are the signed divide ops.
   assign div_signed = !funct3_i[0];
   assign a_neg      = div_signed && op_a_i[XLEN-1];
   assign b_neg      = div_signed && op_b_i[XLEN-1];
   assign abs_a      = a_neg ? -op_a_i : op_a_i;
   assign abs_b      = b_neg ? -op_b_i : op_b_i;

   assign a_sx = (op_q == F3_MULH || op_q == F3_MULHSU) && a_q[XLEN-1];
   assign b_sx = (op_q == F3_MULH) && b_q[XLEN-1];
   assign prod = {{XLEN{a_sx}}, a_q} * {{XLEN{b_sx}}, b_q};

   div_iter #(
      .XLEN (XLEN)
   ) u_div_iter (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (b_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      valid_d   = 1'b0;
      result_d  = result_q;
      rd_out_d  = rd_out_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d = funct3_i;
               rd_d = rd_i;
               if (!funct3_i[2]) begin
                  a_d     = op_a_i;
                  b_d     = op_b_i;
                  state_d = StMul;
               end else begin
                  cnt_d     = '0;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = StFix;
                  if (op_b_i == '0) begin
                     quo_d = '1;
                     rem_d = op_a_i;
                  end else if (div_signed && op_a_i == MinInt && op_b_i == '1) begin
                     quo_d = op_a_i;
                     rem_d = '0;
                  end else begin
                     // quo starts as |a| and is shifted out MSB-first as quotient bits enter.
                     quo_d     = abs_a;
                     b_d       = abs_b;
                     rem_d     = '0;
                     neg_quo_d = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                     state_d   = StDiv;
                  end
               end
            end
         end
         StMul: begin
            state_d = StIdle;
            if (!flush_i) begin
               result_d = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               rd_out_d = rd_q;
               valid_d  = 1'b1;
            end
         end
         StDiv: begin
            if (flush_i) begin
               state_d = StIdle;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!flush_i) begin
               if (op_q[1]) result_d = neg_rem_q ? -rem_q : rem_q;
               else         result_d = neg_quo_q ? -quo_q : quo_q;
               rd_out_d = rd_q;
               valid_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         op_q      <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         valid_q   <= 1'b0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
         rd_out_q  <= rd_out_d;
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign busy_o   = !ready_o;
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results come from an
// arithmetic reference model of the RV32M rules; latencies from the documented timing.
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  is_muldiv_i;
   logic [2:0]  funct3_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   muldiv_unit #(
      .XLEN       (32),
      .REG_ADDR_W (5)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .is_muldiv_i (is_muldiv_i),
      .funct3_i    (funct3_i),
      .op_a_i      (op_a_i),
      .op_b_i      (op_b_i),
      .rd_i        (rd_i),
      .flush_i     (flush_i),
      .valid_o     (valid_o),
      .result_o    (result_o),
      .rd_o        (rd_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: RV32M semantics via wide arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ub, ps;
      logic [63:0] pu;
      logic        ovf;
      int          ia, ib;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'b0, b});
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      pu  = {32'b0, a} * {32'b0, b};
      case (f3)
         3'd0: return pu[31:0];
         3'd1: begin ps = sa * sb; return ps[63:32]; end
         3'd2: begin ps = sa * ub; return ps[63:32]; end
         3'd3: return pu[63:32];
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 0) return 2;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Drive a request for one cycle (cycle 0); returns in cycle 1, #1 after the edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      valid_i     = 1'b1;
      is_muldiv_i = f3[2] ? 2'b10 : 2'b01;
      funct3_i    = f3;
      op_a_i      = a;
      op_b_i      = b;
      rd_i        = rd;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   // Waits (bounded) for valid_o; lat is the cycle index relative to accept, -1 on timeout.
   task automatic wait_valid(output int lat);
      int n = 1;
      while (n <= 40 && valid_o !== 1'b1) begin
         @(posedge clk_i); #1;
         n++;
      end
      lat = (n > 40) ? -1 : n;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; is_muldiv_i = 2'b00;
      funct3_i = 3'd0; op_a_i = '0; op_b_i = '0; rd_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b required 1 0 0",
                  ready_o, busy_o, valid_o);
      end
      checks++;
      if (result_o !== 32'h0 || rd_o !== 5'd0) begin
         failures++;
         $display("FAIL reset_out: result=%h rd=%0d required 0 0", result_o, rd_o);
      end
   endtask

   task automatic test_directed();
      int lat;
      vecs = '{
         '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2},
         '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2},
         '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2},
         '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
         '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
         '{3'd5, 32'd100,       32'd7,         32'd14,        34},
         '{3'd7, 32'd100,       32'd7,         32'd2,         34},
         '{3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 2},
         '{3'd6, 32'h1234_5678, 32'd0,         32'h1234_5678, 2},
         '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2},
         '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2},
         '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2}
      };
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, (i == 0) ? 5'd5 : 5'(i));
         wait_valid(lat);
         checks++;
         if (lat != vecs[i].lat || result_o !== vecs[i].exp ||
             rd_o !== ((i == 0) ? 5'd5 : 5'(i))) begin
            failures++;
            $display("FAIL directed[%0d] f3=%0d: lat=%0d result=%h rd=%0d required lat=%0d result=%h",
                     i, vecs[i].f3, lat, result_o, rd_o, vecs[i].lat, vecs[i].exp);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         rd = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         issue(f3, a, b, rd);
         wait_valid(lat);
         checks++;
         if (lat != model_lat(f3, a, b) || result_o !== model(f3, a, b) || rd_o !== rd) begin
            failures++;
            $display("FAIL random f3=%0d a=%h b=%h: lat=%0d result=%h rd=%0d required lat=%0d result=%h rd=%0d",
                     f3, a, b, lat, result_o, rd_o, model_lat(f3, a, b), model(f3, a, b), rd);
         end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3[8];
      logic [31:0] a[8], b[8];
      int          lat;
      for (int i = 0; i < 8; i++) begin
         f3[i] = 3'($urandom_range(0, 7));
         a[i]  = $urandom;
         b[i]  = (i % 3 == 0) ? 32'h0 : 32'($urandom);
      end
      issue(f3[0], a[0], b[0], 5'd20);
      for (int i = 0; i < 8; i++) begin
         wait_valid(lat);
         checks++;
         if (lat != model_lat(f3[i], a[i], b[i]) || result_o !== model(f3[i], a[i], b[i]) ||
             rd_o !== 5'(20 + i) || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b[%0d]: lat=%0d result=%h rd=%0d ready=%b required lat=%0d result=%h rd=%0d ready=1",
                     i, lat, result_o, rd_o, ready_o, model_lat(f3[i], a[i], b[i]),
                     model(f3[i], a[i], b[i]), 20 + i);
         end
         if (i < 7) issue(f3[i+1], a[i+1], b[i+1], 5'(21 + i));
      end
      @(posedge clk_i); #1;
   endtask

   // Starts a DIV, aborts at cycle 10 with flush or reset, then runs MUL 3x4.
   task automatic test_abort(input bit use_reset);
      int pulses = 0;
      int lat;
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
      repeat (9) begin
         if (valid_o === 1'b1) pulses++;
         @(posedge clk_i); #1;
      end
      if (use_reset) rst_i = 1'b1;
      else           flush_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0; flush_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || pulses != 0) begin
         failures++;
         $display("FAIL abort%0d_cycle11: ready=%b valid=%b early_pulses=%0d required 1 0 0",
                  use_reset, ready_o, valid_o, pulses);
      end
      if (use_reset) begin
         checks++;
         if (result_o !== 32'h0 || rd_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_out: result=%h rd=%0d required 0 0", result_o, rd_o);
         end
      end
      issue(3'd0, 32'd3, 32'd4, 5'd9);
      wait_valid(lat);
      checks++;
      if (lat != 2 || result_o !== 32'd12 || rd_o !== 5'd9) begin
         failures++;
         $display("FAIL abort%0d_mul: lat=%0d result=%h rd=%0d required lat=2 result=c rd=9",
                  use_reset, lat, result_o, rd_o);
      end
      @(posedge clk_i); #1;
      pulses = 0;
      repeat (40) begin
         if (valid_o === 1'b1) pulses++;
         @(posedge clk_i); #1;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL abort%0d_stray: pulses=%0d required 0", use_reset, pulses);
      end
   endtask

   // Flush in the MUL and FIX cycles must suppress completion.
   task automatic test_flush_short();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) issue(3'd0, 32'd5, 32'd6, 5'd1);
         else        issue(3'd5, 32'd5, 32'd0, 5'd1);
         flush_i = 1'b1;
         @(posedge clk_i); #1;
         flush_i = 1'b0;
         checks++;
         if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_short[%0d]: valid=%b ready=%b required 0 1", k, valid_o, ready_o);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_gating();
      int bad = 0;
      valid_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd2; op_b_i = 32'd2; rd_i = 5'd3;
      for (int g = 0; g < 2; g++) begin
         is_muldiv_i = (g == 0) ? 2'b00 : 2'b11;
         repeat (4) begin
            @(posedge clk_i); #1;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) bad++;
         end
      end
      is_muldiv_i = 2'b01; flush_i = 1'b1;
      @(posedge clk_i); #1;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) bad++;
      valid_i = 1'b0; flush_i = 1'b0;
      repeat (3) begin
         @(posedge clk_i); #1;
         if (ready_o !== 1'b1 || valid_o !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL gating_idle: bad_cycles=%0d required 0", bad);
      end

      // Request held high during a busy divide is ignored.
      issue(3'd5, 32'd100, 32'd7, 5'd11);
      valid_i = 1'b1; is_muldiv_i = 2'b01; funct3_i = 3'd0;
      op_a_i = 32'd5; op_b_i = 32'd5; rd_i = 5'd3;
      bad = 0;
      for (int c = 1; c < 34; c++) begin
         if (busy_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0) bad++;
         if (c == 33) valid_i = 1'b0;
         @(posedge clk_i); #1;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL busy_hold: bad_cycles=%0d required 0", bad);
      end
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'd14 || rd_o !== 5'd11) begin
         failures++;
         $display("FAIL busy_result: valid=%b result=%h rd=%0d required 1 e 11",
                  valid_o, result_o, rd_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL busy_after: valid=%b ready=%b required 0 1", valid_o, ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort(1'b0);
      test_abort(1'b1);
      test_flush_short();
      test_gating();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
